// File: rtl/tdm_demux4_if.sv
// Serial-side and frame-side signals of the 4-channel TDM demultiplexer.
// The link/source side is the master; the demux block is the slave.
interface tdm_demux4_if #(
  parameter int W = 8
);
  logic           en;
  logic           din;
  logic           sync;
  logic [4*W-1:0] q;
  logic           vld;
  logic           err;
  logic           locked;

  modport master (
    output en, din, sync,
    input  q, vld, err, locked
  );

  modport slave (
    input  en, din, sync,
    output q, vld, err, locked
  );
endinterface

// File: rtl/tdm_demux4.sv
// 4:1 bit-interleaved TDM receiver: hunts for sync, deals bits round-robin into four channel words.
// q/vld update on the edge sampling the last frame bit; no backpressure, en=0 simply stalls the bit stream.
module tdm_demux4 #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux4_if.slave   bus
);
  localparam int N  = 4 * W;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  ch     [4];
  logic [W-1:0]  ch_nxt [4];
  logic          shift;
  logic [1:0]    lane;
  logic          load;
  logic          vld_nxt;
  logic          err_nxt;
  logic [N-1:0]  q_r;
  logic          vld_r;
  logic          err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift     = 1'b0;
    lane      = cnt[1:0];
    load      = 1'b0;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (bus.en) begin
      case (state)
        HUNT: begin
          if (bus.sync) begin
            shift     = 1'b1;
            lane      = 2'd0;
            cnt_nxt   = ONE;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (cnt == '0) begin
            if (bus.sync) begin
              shift   = 1'b1;
              lane    = 2'd0;
              cnt_nxt = ONE;
            end else begin
              err_nxt   = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HUNT;
            end
          end else if (bus.sync) begin
            // Early sync: abandon the partial frame and restart on this bit.
            err_nxt = 1'b1;
            shift   = 1'b1;
            lane    = 2'd0;
            cnt_nxt = ONE;
          end else begin
            shift = 1'b1;
            if (cnt == LAST) begin
              load    = 1'b1;
              vld_nxt = 1'b1;
              cnt_nxt = '0;
            end else begin
              cnt_nxt = cnt + ONE;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // MSB-first words: shifting left W times parks the first bit of a lane at W-1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_nxt[i] = ch[i];
    end
    if (shift) begin
      ch_nxt[lane] = {ch[lane][W-2:0], bus.din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      q_r   <= '0;
      vld_r <= 1'b0;
      err_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ch[i] <= '0;
      end
    end else begin
      cnt   <= cnt_nxt;
      vld_r <= vld_nxt;
      err_r <= err_nxt;
      for (int i = 0; i < 4; i++) begin
        ch[i] <= ch_nxt[i];
      end
      if (load) begin
        q_r <= {ch_nxt[3], ch_nxt[2], ch_nxt[1], ch_nxt[0]};
      end
    end
  end

  assign bus.q      = q_r;
  assign bus.vld    = vld_r;
  assign bus.err    = err_r;
  assign bus.locked = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: expected frames/errors queued at stimulus time, matched on vld/err.
module tb_tdm_demux4;
  localparam int W = 8;
  localparam int N = 4 * W;

  typedef struct {
    bit           is_err;
    logic [N-1:0] q;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];
  logic [N-1:0] last_q;

  tdm_demux4_if #(.W(W)) bus ();

  tdm_demux4 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic fbit(input logic [N-1:0] f, input int k);
    return f[(k % 4) * W + W - 1 - k / 4];
  endfunction

  function automatic exp_t mk_frame(input logic [N-1:0] f);
    exp_t e;
    e.is_err = 1'b0;
    e.q      = f;
    return e;
  endfunction

  function automatic exp_t mk_err();
    exp_t e;
    e.is_err = 1'b1;
    e.q      = '0;
    return e;
  endfunction

  // One accepted bit: sampled on the next rising edge, returns 1 time unit after it with en low.
  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    bus.en   = 1'b1;
    bus.din  = b;
    bus.sync = s;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.en   = 1'b0;
      bus.din  = 1'($urandom);
      bus.sync = 1'($urandom);
    end
  endtask

  task automatic send_bits(input logic [N-1:0] f, input int from, input int to,
                           input bit use_sync, input bit gaps);
    for (int k = from; k < to; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) gap($urandom_range(1, 4));
      send_bit(fbit(f, k), use_sync && (k == 0));
    end
  endtask

  // Output monitor: every vld/err must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) last_q = '0;
      if (bus.vld && bus.err) chk("vld_err_overlap", 64'(bus.err), 64'(1'b0));
      if (bus.vld) begin
        if (sb.size() == 0) begin
          chk("spurious_vld", 64'(bus.vld), 64'(1'b0));
        end else begin
          e = sb.pop_front();
          chk("vld_order", 64'(e.is_err), 64'(1'b0));
          chk("frame_q", 64'(bus.q), 64'(e.q));
          last_q = e.q;
        end
      end
      if (bus.err) begin
        if (sb.size() == 0) begin
          chk("spurious_err", 64'(bus.err), 64'(1'b0));
        end else begin
          e = sb.pop_front();
          chk("err_order", 64'(e.is_err), 64'(1'b1));
          chk("q_hold_on_err", 64'(bus.q), 64'(last_q));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] f;
    n_vec    = 0;
    n_bad    = 0;
    last_q   = '0;
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.din  = 1'b0;
    bus.sync = 1'b0;

    // Reset, then unsynced bits are ignored
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", 64'(bus.q), 64'd0);
    chk("rst_vld", 64'(bus.vld), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_locked", 64'(bus.locked), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'($urandom), 1'b0);
      chk("hunt_locked", 64'(bus.locked), 64'd0);
    end
    chk("hunt_q", 64'(bus.q), 64'd0);

    // Single frame, continuous en
    f = 32'h00FF3CA5;
    sb.push_back(mk_frame(f));
    send_bits(f, 0, 1, 1'b1, 1'b0);
    chk("lock_first_edge", 64'(bus.locked), 64'd1);
    send_bits(f, 1, N, 1'b1, 1'b0);
    chk("vld_after_last", 64'(bus.vld), 64'd1);
    chk("single_q", 64'(bus.q), 64'h00FF3CA5);
    @(posedge clk);
    #1;
    chk("vld_one_cycle", 64'(bus.vld), 64'd0);

    // Back-to-back frames with random en gaps
    sb.push_back(mk_frame(32'h12345678));
    sb.push_back(mk_frame(32'h87654321));
    send_bits(32'h12345678, 0, N, 1'b1, 1'b1);
    send_bits(32'h87654321, 0, N, 1'b1, 1'b1);
    chk("b2b_q", 64'(bus.q), 64'h87654321);

    // Early sync at bit 13: partial frame dropped, restarted frame delivered
    send_bits(32'hCAFEF00D, 0, 13, 1'b1, 1'b0);
    sb.push_back(mk_err());
    sb.push_back(mk_frame(32'hDEADBEEF));
    send_bits(32'hDEADBEEF, 0, 1, 1'b1, 1'b0);
    chk("early_err", 64'(bus.err), 64'd1);
    chk("early_locked", 64'(bus.locked), 64'd1);
    send_bits(32'hDEADBEEF, 1, N, 1'b1, 1'b0);
    chk("early_q", 64'(bus.q), 64'hDEADBEEF);

    // Missing sync: drop to HUNT, ignore until next sync
    sb.push_back(mk_frame(32'h0F1E2D3C));
    sb.push_back(mk_err());
    sb.push_back(mk_frame(32'h5A5AA5A5));
    send_bits(32'h0F1E2D3C, 0, N, 1'b1, 1'b0);
    send_bits(32'hFFFFFFFF, 0, 1, 1'b0, 1'b0);
    chk("miss_err", 64'(bus.err), 64'd1);
    chk("miss_unlocked", 64'(bus.locked), 64'd0);
    send_bits(32'hFFFFFFFF, 1, N, 1'b0, 1'b0);
    chk("miss_still_hunt", 64'(bus.locked), 64'd0);
    send_bits(32'h5A5AA5A5, 0, N, 1'b1, 1'b1);
    chk("miss_recover_q", 64'(bus.q), 64'h5A5AA5A5);

    // Asynchronous reset at bit 20, between clock edges
    send_bits(32'h13579BDF, 0, 20, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_q", 64'(bus.q), 64'd0);
    chk("arst_vld", 64'(bus.vld), 64'd0);
    chk("arst_err", 64'(bus.err), 64'd0);
    chk("arst_locked", 64'(bus.locked), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_bits(32'h13579BDF, 20, N, 1'b1, 1'b0);
    chk("arst_hunt", 64'(bus.locked), 64'd0);
    chk("arst_q_held", 64'(bus.q), 64'd0);
    sb.push_back(mk_frame(32'h2468ACE0));
    send_bits(32'h2468ACE0, 0, N, 1'b1, 1'b0);
    chk("arst_recover_q", 64'(bus.q), 64'h2468ACE0);

    repeat (4) @(posedge clk);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of a 4:1 bit-interleaved serial link whose transmit side selects one of four data lanes per bit slot. It hunts for a frame-sync marker, locks, distributes incoming serial bits round-robin into four channel shift registers, and presents each completed frame as four parallel W-bit words with a one-cycle valid pulse. Misplaced or missing sync is flagged and drives a realign or a relock.

## Interface
- W, default 8, bits per channel word per frame. Legal range is 2..32. The frame length is 4*W bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  bit strobe; din and sync are sampled only on edges where en=1
- din  in  1  serial data bit
- sync  in  1  frame marker; high with the first bit of each frame
- q  out  4*W  last complete frame; q[W-1:0]=ch0, q[2W-1:W]=ch1, q[3W-1:2W]=ch2, q[4W-1:3W]=ch3
- vld  out  1  one-cycle pulse; new frame on q
- err  out  1  one-cycle pulse; sync violation
- locked  out  1  high while in LOCKED

## Operation
- State machine has two states, HUNT and LOCKED. The bit counter cnt runs over 0..4W-1, width clog2(4W).
- Bit k of a frame (k = cnt) goes to channel k mod 4, at word bit W-1-(k div 4). Each channel word is sent MSB first.
- HUNT:
  - Accepted bits (en=1) with sync=0 are discarded.
  - en=1 with sync=1: store din as ch0 bit W-1, set cnt=1, and go to LOCKED.
- LOCKED, on each accepted bit:
  - cnt=0 and sync=1: normal frame start. Store the bit and set cnt=1.
  - cnt=0 and sync=0: missing sync. Pulse err, go to HUNT, discard the bit, and set cnt=0.
  - cnt≠0 and sync=0: store the bit and increment cnt.
  - cnt≠0 and sync=1: early sync. Pulse err, discard the partial frame (q is not updated and no vld), store the bit as ch0 bit W-1, set cnt=1, and stay LOCKED.
  - cnt=4W-1 (last bit) and sync=0: store the bit, load q with all four assembled words including this bit, pulse vld, and wrap cnt to 0.
- sync while en=0 is ignored. en=0 holds all state; vld and err are 0 on such cycles.
- q holds the last complete frame until the next one completes. Frames discarded by an error never reach q.
- Shift registers need not be cleared between frames, because every bit is overwritten before the next q load.

## Timing
- Reset values, applied immediately on rst_n low and independent of clk: q=0, vld=0, err=0, locked=0, state=HUNT, cnt=0, channel registers=0.
- Reset mid-frame aborts the frame. No vld follows. After release, the block hunts for sync.
- All outputs are registered.
- The edge that samples the last frame bit also updates q and raises vld. vld is high for exactly the following cycle. Latency from the last bit to vld is 1 cycle.
- err rises on the edge that samples the offending bit, for 1 cycle.
- locked rises on the edge that samples the first sync in HUNT. It falls on the edge that samples a missing-sync bit.
- Back-to-back frames with en=1 continuously give a vld every 4W cycles with no dead cycle.
- vld and err are never high in the same cycle.
- en gaps of any length inside a frame are transparent to the result.

## Test plan
1. Reset then HUNT. Hold rst_n=0 for 3 cycles, then release, then send 10 bits with sync=0 -> q=0, vld=0, err=0, locked=0 throughout.
2. Single frame, W=8. Send sync plus 32 bits encoding ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x00 with en=1 continuously -> locked=1 after the first edge; vld=1 for one cycle immediately after bit 31; q=0x00FF3CA5.
3. Back-to-back frames with en gaps. Send frame 0x12345678 then frame 0x87654321, with random en=0 gaps inside the frames -> two vld pulses; q matches each frame in turn; no err.
4. Early sync. Send sync at bit 13 of a frame -> err pulses once; q unchanged; no vld; the frame restarting at that bit completes correctly.
5. Missing sync. Send a complete frame, then the next frame without sync -> err pulses once; locked=0; bits are ignored until the next sync, and the frame following that sync is delivered correctly.
6. Async reset mid-frame. Pull rst_n low at bit 20 of a frame with no clock edge -> q, vld, err, and locked clear immediately; after release, no vld until a full synced frame is received.
